// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer for register FF46: after a start delay, copies one
// source page (echo-remapped) into OAM, one byte per ce_cpu slot.
module oam_dma_ctrl #(
   parameter int unsigned START_DELAY = 1,
   parameter int unsigned XFER_LEN    = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_cpu,
   input  logic        dma_reg_wr,
   input  logic [7:0]  dma_reg_di,
   output logic [7:0]  dma_reg_do,
   output logic [15:0] dma_rd_addr,
   input  logic [7:0]  dma_rd_data,
   output logic        dma_active,
   output logic        oam_wr,
   output logic [7:0]  oam_wr_addr,
   output logic [7:0]  oam_wr_data
);

   localparam int unsigned DW =
      (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
   localparam logic [DW-1:0] DLY_INIT = DW'(START_DELAY);
   localparam logic [DW-1:0] DLY_ONE  = DW'(1);
   localparam logic [7:0]    LEN      = 8'(XFER_LEN);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      XFER
   } state_t;

   state_t        state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [7:0]    rd_idx, rd_idx_n;
   logic [7:0]    idx_inc;
   logic          restart, restart_n;
   logic [7:0]    page_n;
   logic [15:0]   rd_addr_n;
   logic          active_n;
   logic          oam_wr_n;
   logic [7:0]    wa_n;
   logic [7:0]    wd_n;

   // Pages E0..FF alias the C0..DF work RAM.
   function automatic logic [7:0] src_page(input logic [7:0] p);
      return (p >= 8'hE0) ? (p - 8'h20) : p;
   endfunction

   assign idx_inc = rd_idx + 8'd1;

   always_comb begin
      state_n   = state;
      dcnt_n    = dcnt;
      rd_idx_n  = rd_idx;
      restart_n = restart;
      page_n    = dma_reg_do;
      rd_addr_n = dma_rd_addr;
      oam_wr_n  = 1'b0;
      wa_n      = oam_wr_addr;
      wd_n      = oam_wr_data;
      unique case (state)
         IDLE: begin
            if (dma_reg_wr) begin
               page_n    = dma_reg_di;
               dcnt_n    = DLY_INIT;
               restart_n = 1'b0;
               state_n   = DELAY;
            end
         end
         DELAY: begin
            if (dma_reg_wr) begin
               page_n   = dma_reg_di;
               dcnt_n   = DLY_INIT;
               rd_idx_n = 8'd0;
            end else if (dcnt == DLY_ONE) begin
               state_n   = XFER;
               rd_idx_n  = 8'd0;
               rd_addr_n = {src_page(dma_reg_do), 8'h00};
            end else begin
               dcnt_n = dcnt - DLY_ONE;
            end
         end
         XFER: begin
            // A write on any XFER edge, including the last, restarts.
            if (dma_reg_wr) begin
               page_n    = dma_reg_di;
               dcnt_n    = DLY_INIT;
               rd_idx_n  = 8'd0;
               restart_n = 1'b1;
               state_n   = DELAY;
            end else if (rd_idx < LEN) begin
               oam_wr_n = 1'b1;
               wa_n     = rd_idx;
               wd_n     = dma_rd_data;
               rd_idx_n = idx_inc;
               if (idx_inc < LEN) begin
                  rd_addr_n = {src_page(dma_reg_do), idx_inc};
               end
            end else begin
               restart_n = 1'b0;
               state_n   = IDLE;
            end
         end
         default: begin
            state_n   = IDLE;
            restart_n = 1'b0;
         end
      endcase
      active_n = (state_n == XFER) ||
                 ((state_n == DELAY) && restart_n);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         dcnt        <= '0;
         rd_idx      <= 8'd0;
         restart     <= 1'b0;
         dma_reg_do  <= 8'h00;
         dma_rd_addr <= 16'h0000;
         dma_active  <= 1'b0;
         oam_wr      <= 1'b0;
         oam_wr_addr <= 8'h00;
         oam_wr_data <= 8'h00;
      end else if (ce_cpu) begin
         state       <= state_n;
         dcnt        <= dcnt_n;
         rd_idx      <= rd_idx_n;
         restart     <= restart_n;
         dma_reg_do  <= page_n;
         dma_rd_addr <= rd_addr_n;
         dma_active  <= active_n;
         oam_wr      <= oam_wr_n;
         oam_wr_addr <= wa_n;
         oam_wr_data <= wd_n;
      end
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: page table sweep, restart, reset abort,
// stretched ce_cpu and last-edge restart, with an OAM write scoreboard.
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce_cpu = 1'b1;
   logic        dma_reg_wr;
   logic [7:0]  dma_reg_di;
   logic [7:0]  dma_reg_do;
   logic [15:0] dma_rd_addr;
   logic [7:0]  dma_rd_data;
   logic        dma_active;
   logic        oam_wr;
   logic [7:0]  oam_wr_addr;
   logic [7:0]  oam_wr_data;

   oam_dma_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .ce_cpu      (ce_cpu),
      .dma_reg_wr  (dma_reg_wr),
      .dma_reg_di  (dma_reg_di),
      .dma_reg_do  (dma_reg_do),
      .dma_rd_addr (dma_rd_addr),
      .dma_rd_data (dma_rd_data),
      .dma_active  (dma_active),
      .oam_wr      (oam_wr),
      .oam_wr_addr (oam_wr_addr),
      .oam_wr_data (oam_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct packed {
      logic [7:0] page;
      logic [7:0] hi;
   } vec_t;

   wr_t         sb[$];
   vec_t        vecs[6];
   logic [7:0]  oam[256];
   int          tests = 0;
   int          fails = 0;
   int          ce_div = 1;
   int          ce_cnt = 0;
   logic        last_ce = 1'b1;
   logic        last_rst = 1'b1;
   int          wr_clks = 0;
   int          hold_err = 0;
   logic [41:0] snap = '0;

   function automatic logic [7:0] src(input logic [15:0] a);
      logic [7:0] v;
      v = a[7:0] * 8'd3;
      return v ^ a[15:8] ^ 8'h5A;
   endfunction

   assign dma_rd_data = src(dma_rd_addr);

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // One clk: observe at negedge, then advance ce_cpu just after posedge.
   task automatic step();
      logic [41:0] cur;
      wr_t         e;
      @(negedge clk);
      cur = {dma_reg_do, dma_rd_addr, dma_active, oam_wr,
             oam_wr_addr, oam_wr_data};
      if (!last_ce && !last_rst && cur !== snap) hold_err++;
      snap = cur;
      if (oam_wr) wr_clks++;
      if (ce_cpu && oam_wr) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_oam_wr: addr %0h data %0h, want none",
                     oam_wr_addr, oam_wr_data);
         end else begin
            e = sb.pop_front();
            check("oam_wr_addr", {24'h0, oam_wr_addr}, {24'h0, e.a});
            check("oam_wr_data", {24'h0, oam_wr_data}, {24'h0, e.d});
         end
         oam[oam_wr_addr] = oam_wr_data;
      end
      @(posedge clk);
      #1;
      last_ce  = ce_cpu;
      last_rst = reset;
      ce_cnt   = (ce_cnt >= ce_div - 1) ? 0 : ce_cnt + 1;
      ce_cpu   = (ce_cnt == ce_div - 1);
   endtask

   task automatic wait_ce();
      int n;
      n = 0;
      do begin
         step();
         n++;
         if (n > 16) begin
            $display("FAIL wait_ce: no ce_cpu edge in %0d clk, want <=16", n);
            $fatal(1, "ce_cpu stalled");
         end
      end while (!last_ce);
   endtask

   task automatic fwrite(input logic [7:0] p);
      dma_reg_wr = 1'b1;
      dma_reg_di = p;
      wait_ce();
      dma_reg_wr = 1'b0;
   endtask

   task automatic push_xfer(input logic [7:0] hi, input int n);
      for (int k = 0; k < n; k++)
         sb.push_back({8'(k), src({hi, 8'(k)})});
   endtask

   task automatic run_xfer(input logic [7:0] hi, input int n,
                           output int aerr, output int low,
                           output int wslots);
      aerr   = 0;
      low    = 0;
      wslots = 0;
      for (int k = 0; k < n; k++) begin
         wait_ce();
         if (k < 160 && dma_rd_addr !== {hi, 8'(k)}) aerr++;
         if (dma_active !== 1'b1) low++;
         if (oam_wr === 1'b1) wslots++;
      end
   endtask

   task automatic check_oam(input logic [7:0] hi);
      int err;
      err = 0;
      for (int k = 0; k < 160; k++)
         if (oam[k] !== src({hi, 8'(k)})) err++;
      check("oam_contents_bad", err, 0);
   endtask

   task automatic check_idle(input logic [7:0] hi);
      check("idle_active", dma_active, 0);
      check("idle_oam_wr", oam_wr, 0);
      check("idle_rd_addr_hold", dma_rd_addr, {16'h0, hi, 8'h9F});
      check("sb_left", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t, want finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a, l, w;
      vecs[0] = {8'hC1, 8'hC1};
      vecs[1] = {8'hFE, 8'hDE};
      vecs[2] = {8'hE0, 8'hC0};
      vecs[3] = {8'hDF, 8'hDF};
      vecs[4] = {8'hFF, 8'hDF};
      vecs[5] = {8'h00, 8'h00};

      reset      = 1'b1;
      dma_reg_wr = 1'b0;
      dma_reg_di = 8'h00;
      repeat (3) step();
      check("rst_reg_do", dma_reg_do, 0);
      check("rst_rd_addr", dma_rd_addr, 0);
      check("rst_active", dma_active, 0);
      check("rst_oam_wr", oam_wr, 0);
      check("rst_oam_addr", oam_wr_addr, 0);
      check("rst_oam_data", oam_wr_data, 0);
      reset = 1'b0;
      wait_ce();
      check("idle_no_start", dma_active, 0);

      foreach (vecs[i]) begin
         fwrite(vecs[i].page);
         push_xfer(vecs[i].hi, 160);
         check("reg_do", dma_reg_do, {24'h0, vecs[i].page});
         check("delay_active", dma_active, 0);
         check("delay_oam_wr", oam_wr, 0);
         run_xfer(vecs[i].hi, 161, a, l, w);
         check("rd_addr_sweep_bad", a, 0);
         check("xfer_active_low", l, 0);
         check("oam_wr_slots", w, 160);
         wait_ce();
         check_idle(vecs[i].hi);
         check_oam(vecs[i].hi);
      end

      fwrite(8'h80);
      push_xfer(8'h80, 50);
      push_xfer(8'h90, 160);
      run_xfer(8'h80, 51, a, l, w);
      check("rs_first_addr_bad", a, 0);
      check("rs_first_low", l, 0);
      check("rs_first_wr_slots", w, 50);
      dma_reg_wr = 1'b1;
      dma_reg_di = 8'h90;
      wait_ce();
      dma_reg_wr = 1'b0;
      check("rs_delay_active", dma_active, 1);
      check("rs_delay_oam_wr", oam_wr, 0);
      check("rs_reg_do", dma_reg_do, 32'h90);
      run_xfer(8'h90, 161, a, l, w);
      check("rs_second_addr_bad", a, 0);
      check("rs_second_low", l, 0);
      check("rs_second_wr_slots", w, 160);
      wait_ce();
      check_idle(8'h90);
      check_oam(8'h90);

      fwrite(8'hC1);
      push_xfer(8'hC1, 10);
      run_xfer(8'hC1, 11, a, l, w);
      reset = 1'b1;
      step();
      check("rst_mid_active", dma_active, 0);
      check("rst_mid_oam_wr", oam_wr, 0);
      check("rst_mid_reg_do", dma_reg_do, 0);
      reset = 1'b0;
      repeat (20) wait_ce();
      check("rst_mid_sb_left", sb.size(), 0);
      check("rst_mid_rd_addr", dma_rd_addr, 0);
      sb.delete();

      ce_div = 4;
      wait_ce();
      wait_ce();
      hold_err = 0;
      wr_clks  = 0;
      fwrite(8'hC1);
      push_xfer(8'hC1, 160);
      run_xfer(8'hC1, 161, a, l, w);
      check("ce4_addr_bad", a, 0);
      check("ce4_low", l, 0);
      wait_ce();
      check("ce4_wr_clks", wr_clks, 640);
      check("ce4_hold_err", hold_err, 0);
      check_idle(8'hC1);
      check_oam(8'hC1);
      ce_div = 1;
      wait_ce();
      wait_ce();

      fwrite(8'hC1);
      push_xfer(8'hC1, 160);
      push_xfer(8'hD0, 160);
      run_xfer(8'hC1, 161, a, l, w);
      check("last_first_wr_slots", w, 160);
      dma_reg_wr = 1'b1;
      dma_reg_di = 8'hD0;
      wait_ce();
      dma_reg_wr = 1'b0;
      check("last_restart_active", dma_active, 1);
      check("last_restart_oam_wr", oam_wr, 0);
      check("last_reg_do", dma_reg_do, 32'hD0);
      run_xfer(8'hD0, 161, a, l, w);
      check("last_second_addr_bad", a, 0);
      check("last_second_low", l, 0);
      check("last_second_wr_slots", w, 160);
      wait_ce();
      check_idle(8'hD0);
      check_oam(8'hD0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
